midi_rx_splitter: RTL and testbench
===================================

# midi_rx_splitter

Byte classifier between the MIDI UART receiver and the real-time/SysEx FIFO pair that feed the MIDI-bus SysEx mediator. Accepts the raw received byte stream and routes:
- System real-time bytes (F8–FF) to the real-time FIFO.
- Complete SysEx packets (F0 … F7), with an end-of-packet flag on the final byte, to the SysEx FIFO.

It guarantees that every packet written to the SysEx FIFO is properly terminated, including packets truncated by line errors. All other bytes are dropped and counted.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 3_200_000: idle cycles inside a packet before forced termination (≈100 ms at 32 MHz).
- DROP_W, default 16: width of drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  received byte.
- in_valid  in  1  byte available.
- in_ready  out  1  byte consumed this cycle when in_valid && in_ready.
- real_wr  out  1  real-time FIFO write strobe.
- real_wdata  out  8  real-time byte.
- real_full  in  1  real-time FIFO full.
- ex_wr  out  1  SysEx FIFO write strobe.
- ex_wdata  out  8  SysEx byte.
- ex_wlast  out  1  marks final byte (F7) of packet.
- ex_full  in  1  SysEx FIFO full.
- sysex_active  out  1  high while in S_EX.
- drop_count  out  DROP_W  saturating count of discarded bytes.

## Operation
- FSM states: S_IDLE, S_EX. Reset → S_IDLE.
- Outputs reset values: in_ready=0, real_wr=0, ex_wr=0, ex_wlast=0, sysex_active=0, drop_count=0.
- Real-time byte (in_data ≥ F8), any state:
  - in_ready = !real_full. On accept, real_wr=1 and real_wdata=in_data.
  - State unchanged; timeout counter not cleared.
- S_IDLE:
  - F0: in_ready = !ex_full. On accept, write F0 (wlast=0) and go to S_EX.
  - Any other non-real-time byte (data 00–7F, 80–EF, F1–F7): consumed unconditionally (in_ready=1), drop_count++.
- S_EX:
  - Data byte 00–7F: in_ready = !ex_full. On accept, write byte with wlast=0.
  - F7: in_ready = !ex_full. On accept, write F7 with wlast=1 and go to S_IDLE.
  - F0 (new packet start): when !ex_full, write synthesized F7 with wlast=1, go to S_IDLE, in_ready=0. The F0 is accepted the following cycle via the S_IDLE rule.
  - Any other status byte (80–EF, F1–F6): in_ready = !ex_full. On accept, write synthesized F7 with wlast=1, go to S_IDLE, drop_count++.
- drop_count saturates at all-ones.
- At most one write per FIFO per cycle. ex_wr and real_wr are never both high.

## Timing
- All write strobes are combinational from in_valid/in_data/state/full flags, so an accepted byte is written in the same cycle (zero latency).
- State and counters update on the rising edge after acceptance.
- A synthesized F7 costs exactly one cycle, with in_ready=0 during it.
- A full FIFO stalls only bytes destined for it. A SysEx stall blocks the input even if a real-time byte is queued behind it (in-order input).
- Timeout counter:
  - Clears on entering S_EX and on every accepted SysEx-path byte.
  - Increments each S_EX cycle otherwise.
  - At TIMEOUT_CYCLES with !ex_full: write F7 with wlast=1, go to S_IDLE, force in_ready=0 that cycle.
  - Timeout has priority over input. If ex_full, the forced termination waits.
- Reset mid-packet: returns to S_IDLE without emitting F7. The downstream FIFO is reset together with this block.

## Configuration
- MIDI_SPLIT_TIMEOUT_EN defined: timeout counter and forced termination present.
- Undefined: no counter. Packets end only on F7, F0 or another status byte, and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package midi_pkg:
  - state enum {S_IDLE, S_EX}.
  - Constants MIDI_SOX=8'hF0, MIDI_EOX=8'hF7, MIDI_RT_MIN=8'hF8.
  - Helper functions is_realtime(b) and is_status(b).
- One natural sub-module: midi_sysex_timeout (counter with clear/enable/expire), instantiated only under MIDI_SPLIT_TIMEOUT_EN.

## Test plan
- F0 41 10 F7 with both FIFOs empty → ex writes F0/0, 41/0, 10/0, F7/1 on consecutive cycles; drop_count=0.
- F0 41 F8 10 F7 → real FIFO receives F8; ex stream F0 41 10 F7, last only on F7; sysex_active stays high across F8.
- F0 41 90 3C → ex F0 41 F7(last); 90 counted (drop_count=1); 3C dropped (drop_count=2); state S_IDLE.
- F0 41 F0 42 F7 → ex F0 41 F7(last) F0 42 F7(last); in_ready low exactly one cycle at second F0.
- ex_full held high for 5 cycles mid-packet with an F8 next on input → in_ready=0, no writes for 5 cycles; stream resumes intact in order.
- With MIDI_SPLIT_TIMEOUT_EN and TIMEOUT_CYCLES=16: F0 01 then silence → F7 with wlast=1 written 16 cycles after the 01 is accepted; then 02 → dropped, drop_count=1.

Source files
------------

// File: rtl/midi_rx_splitter_pkg.sv
// Shared MIDI definitions: splitter state encoding, framing constants and byte-class helpers.
package midi_pkg;

  typedef enum logic {
    S_IDLE,
    S_EX
  } state_t;

  localparam logic [7:0] MIDI_SOX    = 8'hF0;
  localparam logic [7:0] MIDI_EOX    = 8'hF7;
  localparam logic [7:0] MIDI_RT_MIN = 8'hF8;

  function automatic logic is_realtime(input logic [7:0] b);
    return b >= MIDI_RT_MIN;
  endfunction

  function automatic logic is_status(input logic [7:0] b);
    return b >= 8'h80;
  endfunction

endpackage

// File: rtl/midi_sysex_timeout.sv
// Idle-cycle counter for an open SysEx packet; o_expire asserts once TIMEOUT_CYCLES idle cycles have elapsed.
module midi_sysex_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 3_200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned   CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // The expiring cycle is itself the last idle cycle, hence the compare against TIMEOUT_CYCLES-1.
  assign o_expire = i_enable && (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/midi_rx_splitter.sv
// Routes received MIDI bytes to real-time and SysEx FIFOs, always terminating SysEx packets.
// Define MIDI_SPLIT_TIMEOUT_EN to add forced termination after TIMEOUT_CYCLES idle cycles.
module midi_rx_splitter
  import midi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 3_200_000,
  parameter int unsigned DROP_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              real_wr,
  output logic [7:0]        real_wdata,
  input  logic              real_full,
  output logic              ex_wr,
  output logic [7:0]        ex_wdata,
  output logic              ex_wlast,
  input  logic              ex_full,
  output logic              sysex_active,
  output logic [DROP_W-1:0] drop_count
);

  state_t            r_state;
  state_t            w_next;
  logic [DROP_W-1:0] r_drop;
  logic              w_drop;
  logic              w_ex_go;
  logic              w_ex_accept;
  logic              w_expire;

`ifdef MIDI_SPLIT_TIMEOUT_EN
  midi_sysex_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  ((r_state != S_EX) || w_ex_accept),
    .i_enable (r_state == S_EX),
    .o_expire (w_expire)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_expire             = 1'b0;
`endif

  always_comb begin
    in_ready    = 1'b0;
    real_wr     = 1'b0;
    real_wdata  = in_data;
    ex_wr       = 1'b0;
    ex_wdata    = in_data;
    ex_wlast    = 1'b0;
    w_next      = r_state;
    w_drop      = 1'b0;
    w_ex_go     = in_valid && !ex_full;
    w_ex_accept = 1'b0;
    if (!rst) begin
      if ((r_state == S_EX) && w_expire) begin
        if (!ex_full) begin
          ex_wr    = 1'b1;
          ex_wdata = MIDI_EOX;
          ex_wlast = 1'b1;
          w_next   = S_IDLE;
        end
      end else if (is_realtime(in_data)) begin
        in_ready = !real_full;
        real_wr  = in_valid && !real_full;
      end else if (r_state == S_IDLE) begin
        if (in_data == MIDI_SOX) begin
          in_ready    = !ex_full;
          ex_wr       = w_ex_go;
          w_ex_accept = w_ex_go;
          if (w_ex_go) w_next = S_EX;
        end else begin
          in_ready = 1'b1;
          w_drop   = in_valid;
        end
      end else if (!is_status(in_data) || (in_data == MIDI_EOX)) begin
        in_ready    = !ex_full;
        ex_wr       = w_ex_go;
        ex_wlast    = w_ex_go && (in_data == MIDI_EOX);
        w_ex_accept = w_ex_go;
        if (w_ex_go && (in_data == MIDI_EOX)) w_next = S_IDLE;
      end else begin
        // A new F0 is held back one cycle so the synthesized F7 lands first; it is re-taken from S_IDLE.
        in_ready = (in_data != MIDI_SOX) && !ex_full;
        ex_wr    = w_ex_go;
        ex_wdata = MIDI_EOX;
        ex_wlast = w_ex_go;
        w_drop   = w_ex_go && (in_data != MIDI_SOX);
        if (w_ex_go) w_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign sysex_active = (r_state == S_EX);
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_midi_rx_splitter.sv
// Self-checking bench for midi_rx_splitter: directed scenarios plus randomized traffic vs a stream-level model.
`timescale 1ns/1ps
module tb_midi_rx_splitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       real_wr;
  logic [7:0] real_wdata;
  logic       real_full = 1'b0;
  logic       ex_wr;
  logic [7:0] ex_wdata;
  logic       ex_wlast;
  logic       ex_full = 1'b0;
  logic       sysex_active;
  logic [3:0] drop_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic       s_rdy, s_rwr, s_xwr, s_xlast, s_act;
  logic [7:0] s_rdat, s_xdat;
  logic [3:0] s_drop;

  logic [8:0] ex_q[$];
  logic [7:0] rt_q[$];
  logic [7:0] acc_q[$];

  always #5 clk = ~clk;

  midi_rx_splitter #(
    .TIMEOUT_CYCLES(16),
    .DROP_W(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .real_wr      (real_wr),
    .real_wdata   (real_wdata),
    .real_full    (real_full),
    .ex_wr        (ex_wr),
    .ex_wdata     (ex_wdata),
    .ex_wlast     (ex_wlast),
    .ex_full      (ex_full),
    .sysex_active (sysex_active),
    .drop_count   (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample mid low phase, log writes and accepted bytes.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rf, input logic xf);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    real_full = rf;
    ex_full   = xf;
    #2;
    s_rdy   = in_ready;
    s_rwr   = real_wr;
    s_rdat  = real_wdata;
    s_xwr   = ex_wr;
    s_xdat  = ex_wdata;
    s_xlast = ex_wlast;
    s_act   = sysex_active;
    s_drop  = drop_count;
    if (!rst) chk("wr_conflict", {29'd0, s_xwr & xf, s_rwr & rf, s_xwr & s_rwr}, 32'd0);
    if (s_xwr) ex_q.push_back({s_xlast, s_xdat});
    if (s_rwr) rt_q.push_back(s_rdat);
    if (v && s_rdy && !rst) acc_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 8'hF8, 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    chk("rst_ready", s_rdy, 0);
    chk("rst_writes", {s_rwr, s_xwr, s_xlast}, 0);
    chk("rst_active", s_act, 0);
    chk("rst_drop", s_drop, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    ex_q.delete();
    rt_q.delete();
    acc_q.delete();
  endtask

  task automatic put(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
    chk("put_accept", s_rdy, 1);
  endtask

  // Reference: derive FIFO streams and drop count from the accepted byte sequence alone.
  task automatic check_streams(input string tag);
    logic [8:0]  eq[$];
    logic [7:0]  rq[$];
    int unsigned drops = 0;
    bit          open = 0;
    logic [7:0]  b;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    foreach (acc_q[i]) begin
      b = acc_q[i];
      if (b >= 8'hF8) rq.push_back(b);
      else if (!open) begin
        if (b == 8'hF0) begin eq.push_back({1'b0, b}); open = 1; end
        else drops++;
      end else if (b < 8'h80) eq.push_back({1'b0, b});
      else if (b == 8'hF7) begin eq.push_back({1'b1, b}); open = 0; end
      else if (b == 8'hF0) begin eq.push_back(9'h1F7); eq.push_back(9'h0F0); end
      else begin eq.push_back(9'h1F7); open = 0; drops++; end
    end
    chk({tag, "_ex_len"}, ex_q.size(), eq.size());
    for (int i = 0; i < eq.size() && i < ex_q.size(); i++) chk({tag, "_ex_byte"}, ex_q[i], eq[i]);
    chk({tag, "_rt_len"}, rt_q.size(), rq.size());
    for (int i = 0; i < rq.size() && i < rt_q.size(); i++) chk({tag, "_rt_byte"}, rt_q[i], rq[i]);
    chk({tag, "_drop"}, s_drop, (drops > 15) ? 15 : drops);
    chk({tag, "_active"}, s_act, open);
  endtask

  logic [7:0] pat1[4] = '{8'hF0, 8'h41, 8'h10, 8'hF7};

  initial begin
    int unsigned rt_run;
    int unsigned n;
    logic [7:0]  b;
    logic        xf_prev, rf_prev, xf, rf;

    // Basic packet, one write per cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pat1[i], 1'b0, 1'b0);
      chk("t1_ready", s_rdy, 1);
      chk("t1_wr", s_xwr, 1);
      chk("t1_data", s_xdat, pat1[i]);
      chk("t1_last", s_xlast, (i == 3));
    end
    check_streams("t1");

    // Real-time byte inside a packet
    do_reset();
    put(8'hF0); put(8'h41);
    put(8'hF8);
    chk("t2_rt_wr", s_rwr, 1);
    chk("t2_rt_ex", s_xwr, 0);
    chk("t2_active", s_act, 1);
    put(8'h10); put(8'hF7);
    check_streams("t2");

    // Status byte truncates the packet, following data byte dropped
    do_reset();
    put(8'hF0); put(8'h41); put(8'h90); put(8'h3C);
    check_streams("t3");

    // Back-to-back F0 costs one bubble cycle
    do_reset();
    put(8'hF0); put(8'h41);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    chk("t4_bubble_ready", s_rdy, 0);
    chk("t4_bubble_eox", {s_xwr, s_xlast, s_xdat}, {2'b11, 8'hF7});
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    chk("t4_sox_ready", s_rdy, 1);
    chk("t4_sox", {s_xwr, s_xlast, s_xdat}, {2'b10, 8'hF0});
    put(8'h42); put(8'hF7);
    check_streams("t4");

    // SysEx stall holds the input; F8 queued behind waits
    do_reset();
    put(8'hF0); put(8'h41);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h42, 1'b0, 1'b1);
      chk("t5_stall_ready", s_rdy, 0);
      chk("t5_stall_wr", {s_xwr, s_rwr}, 0);
    end
    put(8'h42); put(8'hF8); put(8'hF7);
    check_streams("t5");

    // Real-time stall
    do_reset();
    cyc(1'b1, 8'hFE, 1'b1, 1'b0);
    chk("t6_rt_stall", {s_rdy, s_rwr}, 0);
    cyc(1'b1, 8'hFE, 1'b0, 1'b1);
    chk("t6_rt_go", {s_rdy, s_rwr}, 2'b11);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) put(8'($urandom_range(0, 127)));
    check_streams("t7");

`ifdef MIDI_SPLIT_TIMEOUT_EN
    do_reset();
    put(8'hF0); put(8'h01);
    n = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (s_xwr) begin n = k; break; end
    end
    chk("to_delay", n, 16);
    chk("to_eox", {s_xlast, s_xdat}, {1'b1, 8'hF7});
    put(8'h02);
    check_streams("to");
`else
    do_reset();
    put(8'hF0); put(8'h01);
    for (int k = 0; k < 40; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("noto_active", s_act, 1);
    chk("noto_writes", ex_q.size(), 2);
`endif

    // Randomized traffic with short gaps and single-cycle full pulses
    do_reset();
    rt_run = 0; xf_prev = 0; rf_prev = 0;
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      if (n < 12 && rt_run < 2) begin b = 8'($urandom_range(8'hF8, 8'hFF)); rt_run++; end
      else begin
        rt_run = 0;
        if (n < 24)      b = 8'hF0;
        else if (n < 32) b = 8'hF7;
        else if (n < 40) b = 8'($urandom_range(8'h80, 8'hEF));
        else if (n < 43) b = 8'($urandom_range(8'hF1, 8'hF6));
        else             b = 8'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      n = 0;
      do begin
        xf = !xf_prev && ($urandom_range(0, 3) == 0);
        rf = !rf_prev && ($urandom_range(0, 3) == 0);
        xf_prev = xf; rf_prev = rf;
        cyc(1'b1, b, rf, xf);
        n++;
      end while (!s_rdy && n < 20);
      if (!s_rdy) chk("rand_accept_bound", 0, 1);
    end
    check_streams("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
